// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: pops fetch-side branch predictions at Execute, trains the predictor, redirects and flushes on mispredict
module branch_resolve_unit #(
  parameter int DEPTH = 4,
  parameter int RECOVER_CYC = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fe_push,
  input  logic [31:0]      fe_pc,
  input  logic             fe_pred_take,
  output logic             fe_full,
  input  logic             ex_vld,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  output logic             upd_vld,
  output logic             upd_taken,
  output logic [31:0]      upd_pc,
  output logic             redirect_vld,
  output logic [31:0]      redirect_pc,
  output logic             in_recover,
  output logic             err_overflow,
  output logic             err_underflow,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mis_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = $clog2(RECOVER_CYC + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [RW-1:0] REC_LD = RW'(RECOVER_CYC);
  typedef enum logic {RUN, RECOVER} state_t;
  state_t state, state_d;
  logic [RW-1:0] rec_cnt, rec_cnt_d;
  logic [31:0] pc_q [DEPTH];
  logic pred_q [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic pop, mis, push_ok;
  assign pop = ex_vld && count != '0;
  assign mis = pop && (pred_q[rd_ptr] != ex_taken);
  assign push_ok = fe_push && state == RUN && (count != FULL || pop) && !mis;
  assign fe_full = count == FULL;
  assign in_recover = state == RECOVER;
  always_comb begin
    state_d = mis ? RECOVER : (state == RECOVER && rec_cnt == RW'(1)) ? RUN : state;
    rec_cnt_d = mis ? REC_LD : in_recover ? rec_cnt - 1'b1 : rec_cnt;
  end
  always_ff @(posedge clk) begin
    if (push_ok) begin
      pc_q[wr_ptr] <= fe_pc;
      pred_q[wr_ptr] <= fe_pred_take;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      rec_cnt <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      upd_vld <= 1'b0;
      upd_taken <= 1'b0;
      upd_pc <= '0;
      redirect_vld <= 1'b0;
      redirect_pc <= '0;
      err_overflow <= 1'b0;
      err_underflow <= 1'b0;
      br_cnt <= '0;
      mis_cnt <= '0;
    end else begin
      state <= state_d;
      rec_cnt <= rec_cnt_d;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (mis) begin
        rd_ptr <= wr_ptr;
        count <= '0;
      end else begin
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push_ok) - CW'(pop);
      end
      upd_vld <= pop;
      redirect_vld <= mis;
      if (pop) begin
        upd_taken <= ex_taken;
        upd_pc <= pc_q[rd_ptr];
      end
      if (pop && !(&br_cnt)) br_cnt <= br_cnt + 1'b1;
      if (mis) redirect_pc <= ex_taken ? ex_target : pc_q[rd_ptr] + 32'd4;
      if (mis && !(&mis_cnt)) mis_cnt <= mis_cnt + 1'b1;
      if (fe_push && state == RUN && fe_full && !pop) err_overflow <= 1'b1;
      if (ex_vld && count == '0) err_underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: table-driven directed check of branch_resolve_unit
module tb_branch_resolve_unit;
  logic clk = 1'b0;
  logic rst, fe_push, fe_pred_take, ex_vld, ex_taken;
  logic [31:0] fe_pc, ex_target;
  logic fe_full, upd_vld, upd_taken, redirect_vld, in_recover, err_overflow, err_underflow;
  logic [31:0] upd_pc, redirect_pc, br_cnt, mis_cnt;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  branch_resolve_unit #(.DEPTH(4), .RECOVER_CYC(2), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .fe_push(fe_push), .fe_pc(fe_pc), .fe_pred_take(fe_pred_take), .fe_full(fe_full),
    .ex_vld(ex_vld), .ex_taken(ex_taken), .ex_target(ex_target),
    .upd_vld(upd_vld), .upd_taken(upd_taken), .upd_pc(upd_pc),
    .redirect_vld(redirect_vld), .redirect_pc(redirect_pc), .in_recover(in_recover),
    .err_overflow(err_overflow), .err_underflow(err_underflow),
    .br_cnt(br_cnt), .mis_cnt(mis_cnt)
  );
  typedef struct {
    logic rst, push;
    logic [31:0] pc;
    logic pred, exv, ext;
    logic [31:0] tgt;
    logic full, uv, ut;
    logic [31:0] upc;
    logic rv;
    logic [31:0] rpc;
    logic rec, ovf, unf;
    logic [31:0] br, mis;
  } vec_t;
  vec_t tv[$];
  task automatic add(input logic r, input logic p, input logic [31:0] pc, input logic pr,
                     input logic ev, input logic et, input logic [31:0] tg,
                     input logic fu, input logic uv, input logic ut, input logic [31:0] upc,
                     input logic rv, input logic [31:0] rpc, input logic rec,
                     input logic ovf, input logic unf, input logic [31:0] br, input logic [31:0] mis);
    vec_t v;
    v.rst = r; v.push = p; v.pc = pc; v.pred = pr; v.exv = ev; v.ext = et; v.tgt = tg;
    v.full = fu; v.uv = uv; v.ut = ut; v.upc = upc; v.rv = rv; v.rpc = rpc;
    v.rec = rec; v.ovf = ovf; v.unf = unf; v.br = br; v.mis = mis;
    tv.push_back(v);
  endtask
  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %h expected %h", name, row, act, exp);
    end
  endtask
  task automatic apply(input vec_t v, input int row);
    rst = v.rst; fe_push = v.push; fe_pc = v.pc; fe_pred_take = v.pred;
    ex_vld = v.exv; ex_taken = v.ext; ex_target = v.tgt;
    @(posedge clk);
    #1;
    chk("fe_full", row, 32'(fe_full), 32'(v.full));
    chk("upd_vld", row, 32'(upd_vld), 32'(v.uv));
    chk("upd_taken", row, 32'(upd_taken), 32'(v.ut));
    chk("upd_pc", row, upd_pc, v.upc);
    chk("redirect_vld", row, 32'(redirect_vld), 32'(v.rv));
    chk("redirect_pc", row, redirect_pc, v.rpc);
    chk("in_recover", row, 32'(in_recover), 32'(v.rec));
    chk("err_overflow", row, 32'(err_overflow), 32'(v.ovf));
    chk("err_underflow", row, 32'(err_underflow), 32'(v.unf));
    chk("br_cnt", row, br_cnt, v.br);
    chk("mis_cnt", row, mis_cnt, v.mis);
  endtask
  initial begin
    vec_t h;
    rst = 1'b1; fe_push = 0; fe_pc = 0; fe_pred_take = 0; ex_vld = 0; ex_taken = 0; ex_target = 0;
    //  rst push pc           pred exv ext tgt      full uv ut upc          rv rpc    rec ovf unf br mis
    add(1, 0, 0,            0, 0, 0, 0,        0, 0, 0, 0,            0, 0,     0, 0, 0, 0, 0);
    add(0, 0, 0,            0, 1, 0, 0,        0, 0, 0, 0,            0, 0,     0, 0, 1, 0, 0);
    add(0, 1, 'h100,        1, 0, 0, 0,        0, 0, 0, 0,            0, 0,     0, 0, 1, 0, 0);
    add(0, 0, 0,            0, 1, 1, 'h500,    0, 1, 1, 'h100,        0, 0,     0, 0, 1, 1, 0);
    add(0, 1, 'h200,        0, 0, 0, 0,        0, 0, 1, 'h100,        0, 0,     0, 0, 1, 1, 0);
    add(0, 1, 'h204,        1, 0, 0, 0,        0, 0, 1, 'h100,        0, 0,     0, 0, 1, 1, 0);
    add(0, 0, 0,            0, 1, 1, 'h400,    0, 1, 1, 'h200,        1, 'h400, 1, 0, 1, 2, 1);
    add(0, 1, 'h300,        1, 0, 0, 0,        0, 0, 1, 'h200,        0, 'h400, 1, 0, 1, 2, 1);
    add(0, 1, 'h304,        0, 0, 0, 0,        0, 0, 1, 'h200,        0, 'h400, 0, 0, 1, 2, 1);
    add(0, 0, 0,            0, 1, 0, 0,        0, 0, 1, 'h200,        0, 'h400, 0, 0, 1, 2, 1);
    add(0, 1, 'hFFFFFFFC,   1, 0, 0, 0,        0, 0, 1, 'h200,        0, 'h400, 0, 0, 1, 2, 1);
    add(0, 0, 0,            0, 1, 0, 'h999,    0, 1, 0, 'hFFFFFFFC,   1, 0,     1, 0, 1, 3, 2);
    add(0, 0, 0,            0, 0, 0, 0,        0, 0, 0, 'hFFFFFFFC,   0, 0,     1, 0, 1, 3, 2);
    add(0, 0, 0,            0, 0, 0, 0,        0, 0, 0, 'hFFFFFFFC,   0, 0,     0, 0, 1, 3, 2);
    add(0, 1, 'h10,         0, 0, 0, 0,        0, 0, 0, 'hFFFFFFFC,   0, 0,     0, 0, 1, 3, 2);
    add(0, 1, 'h14,         0, 0, 0, 0,        0, 0, 0, 'hFFFFFFFC,   0, 0,     0, 0, 1, 3, 2);
    add(0, 1, 'h18,         1, 0, 0, 0,        0, 0, 0, 'hFFFFFFFC,   0, 0,     0, 0, 1, 3, 2);
    add(0, 1, 'h1C,         0, 0, 0, 0,        1, 0, 0, 'hFFFFFFFC,   0, 0,     0, 0, 1, 3, 2);
    add(0, 1, 'h20,         1, 0, 0, 0,        1, 0, 0, 'hFFFFFFFC,   0, 0,     0, 1, 1, 3, 2);
    add(0, 1, 'h24,         0, 1, 0, 0,        1, 1, 0, 'h10,         0, 0,     0, 1, 1, 4, 2);
    add(0, 0, 0,            0, 1, 0, 0,        0, 1, 0, 'h14,         0, 0,     0, 1, 1, 5, 2);
    add(0, 0, 0,            0, 1, 1, 'h40,     0, 1, 1, 'h18,         0, 0,     0, 1, 1, 6, 2);
    add(0, 0, 0,            0, 1, 0, 0,        0, 1, 0, 'h1C,         0, 0,     0, 1, 1, 7, 2);
    add(0, 0, 0,            0, 1, 1, 'h80,     0, 1, 1, 'h24,         1, 'h80,  1, 1, 1, 8, 3);
    add(0, 0, 0,            0, 0, 0, 0,        0, 0, 1, 'h24,         0, 'h80,  1, 1, 1, 8, 3);
    add(0, 0, 0,            0, 0, 0, 0,        0, 0, 1, 'h24,         0, 'h80,  0, 1, 1, 8, 3);
    add(0, 1, 'h50,         0, 0, 0, 0,        0, 0, 1, 'h24,         0, 'h80,  0, 1, 1, 8, 3);
    add(0, 1, 'h54,         1, 0, 0, 0,        0, 0, 1, 'h24,         0, 'h80,  0, 1, 1, 8, 3);
    add(0, 1, 'h58,         1, 0, 0, 0,        0, 0, 1, 'h24,         0, 'h80,  0, 1, 1, 8, 3);
    foreach (tv[i]) apply(tv[i], i);
    // reset lands on the same edge as a mispredicting pop with three entries held
    h = tv[0];
    h.exv = 1; h.ext = 1; h.tgt = 'h600;
    apply(h, 100);
    // FIFO must be empty afterwards: a pop underflows and produces no update
    h = tv[1];
    apply(h, 101);
    h = tv[2];
    h.pc = 'h70; h.pred = 0;
    apply(h, 102);
    h = tv[3];
    h.ext = 0; h.ut = 0; h.upc = 'h70;
    apply(h, 103);
    // back-to-back: two pops on consecutive cycles give consecutive pulses
    h = tv[2]; h.pc = 'h80; h.pred = 1; h.ut = 0; h.upc = 'h70; h.br = 1;
    apply(h, 104);
    h.pc = 'h84; h.pred = 0;
    apply(h, 105);
    h.push = 0; h.exv = 1; h.ext = 1; h.tgt = 'h900; h.uv = 1; h.ut = 1; h.upc = 'h80; h.br = 2;
    apply(h, 106);
    h.ext = 0; h.ut = 0; h.upc = 'h84; h.br = 3;
    apply(h, 107);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
